// File: rtl/tremolo_mod.sv
// Tremolo amplitude modulator: scales signed samples by an LFO-derived gain through a
// 2-stage valid/ready pipeline and paces the upstream NCO with a rate-divided advance pulse.
module tremolo_mod #(
  parameter int W = 24,
  parameter int N = 8,
  parameter int D = 8,
  parameter int R = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [D-1:0]        depth,
  input  logic [R-1:0]        rate,
  input  logic [N-1:0]        lfo,
  output logic                lfo_nxt,
  input  logic signed [W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  logic                s2_advance;
  logic                accept;
  logic [N+D-1:0]      scaled;
  logic [N-1:0]        gain;
  logic signed [W+N:0] prod;

  logic                s1_valid_q, s1_valid_d;
  logic                s1_en_q, s1_en_d;
  logic signed [W-1:0] s1_data_q, s1_data_d;
  logic [N-1:0]        s1_gain_q, s1_gain_d;
  logic                out_valid_q, out_valid_d;
  logic signed [W-1:0] out_data_q, out_data_d;
  logic [R-1:0]        cnt_q, cnt_d;
  logic                nxt_q, nxt_d;

  assign s2_advance = ~out_valid_q | out_ready;
  assign in_ready   = ~s1_valid_q | s2_advance;
  assign accept     = in_valid & in_ready;

  always_comb begin
    // (2^N-1) - x equals ~x in N bits; ~lfo likewise gives (2^N-1) - lfo.
    scaled = {{N{1'b0}}, depth} * {{D{1'b0}}, ~lfo};
    gain   = ~N'(scaled >> D);
    prod   = {{(N+1){s1_data_q[W-1]}}, s1_data_q} * {{(W+1){1'b0}}, s1_gain_q};

    s1_valid_d  = s1_valid_q;
    s1_en_d     = s1_en_q;
    s1_data_d   = s1_data_q;
    s1_gain_d   = s1_gain_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (s2_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = s1_en_q ? W'(prod >>> N) : s1_data_q;
      end
    end

    if (in_ready) begin
      s1_valid_d = in_valid;
      if (accept) begin
        s1_en_d   = en;
        s1_data_d = in_data;
        s1_gain_d = gain;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    nxt_d = 1'b0;
    if (!en || rate == '0) begin
      cnt_d = '0;
    end else if (accept) begin
      // >= rather than == so a lowered rate wraps at once instead of running through 2^R.
      if (cnt_q >= rate - R'(1)) begin
        cnt_d = '0;
        nxt_d = 1'b1;
      end else begin
        cnt_d = cnt_q + R'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_en_q     <= 1'b0;
      s1_data_q   <= '0;
      s1_gain_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cnt_q       <= '0;
      nxt_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_en_q     <= s1_en_d;
      s1_data_q   <= s1_data_d;
      s1_gain_q   <= s1_gain_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
      nxt_q       <= nxt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign lfo_nxt   = nxt_q;

endmodule

// File: tb/tb_tremolo_mod.sv
// Self-checking bench for tremolo_mod: directed cases plus random traffic against an
// arithmetic reference model (expected-output queue and rate-pulse counter).
module tb_tremolo_mod;
  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic [7:0]         depth;
  logic [15:0]        rate;
  logic [7:0]         lfo;
  logic               lfo_nxt;
  logic signed [23:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic signed [23:0] out_data;
  logic               out_valid;
  logic               out_ready;

  tremolo_mod dut (
    .clk(clk), .rst_n(rst_n), .en(en), .depth(depth), .rate(rate), .lfo(lfo),
    .lfo_nxt(lfo_nxt), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int     tests = 0;
  int     fails = 0;
  longint q[$];
  int     cnt_m = 0;
  int     pulses = 0;
  int     n_out = 0;
  bit     last_acc;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference gain law: G = 255 - floor(depth*(255-lfo)/256); out = floor(x*G/256).
  function automatic longint model_out(longint x, bit e, int dep, int l);
    longint g;
    if (!e) return x;
    g = 255 - (dep * (255 - l)) / 256;
    return (x * g) >>> 8;
  endfunction

  // One clock: check in_ready/outputs before the edge, update model, check after the edge.
  task automatic tick();
    bit                 acc, take, stall, exp_pulse;
    logic signed [23:0] held;
    #1;
    chk("in_ready", in_ready, (q.size() < 2 || out_ready) ? 1 : 0);
    acc   = in_valid && in_ready;
    take  = out_valid && out_ready;
    stall = out_valid && !out_ready;
    held  = out_data;
    if (take) begin
      chk("out_expected", q.size() > 0 ? 1 : 0, 1);
      if (q.size() > 0) chk("out_data", out_data, q.pop_front());
      n_out++;
    end
    if (acc) q.push_back(model_out(in_data, en, int'(depth), int'(lfo)));
    if (!en || rate == 0) begin
      cnt_m = 0;
      exp_pulse = 0;
    end else if (acc) begin
      if (cnt_m >= int'(rate) - 1) begin
        cnt_m = 0;
        exp_pulse = 1;
      end else begin
        cnt_m++;
        exp_pulse = 0;
      end
    end else begin
      exp_pulse = 0;
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    chk("lfo_nxt", lfo_nxt, exp_pulse);
    if (lfo_nxt) pulses++;
    if (stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, held);
    end
  endtask

  // Single sample into an empty pipeline; output must appear exactly two cycles on.
  task automatic send_one(input logic signed [23:0] d, input longint exp, input string tag);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, out_valid, 0);
    tick();
    chk({tag, "_valid"}, out_valid, 1);
    chk(tag, out_data, exp);
    tick();
  endtask

  initial begin
    int base, sent;
    logic signed [23:0] stim [8];
    rst_n = 1'b0; en = 1'b0; depth = '0; rate = '0; lfo = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_lfo_nxt", lfo_nxt, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    en = 1'b1; depth = 8'd0; lfo = 8'd77;
    send_one(24'sd1000, 996, "d0_pos");
    send_one(-24'sd1000, -997, "d0_neg");
    depth = 8'd255; lfo = 8'd0;
    send_one(24'sd1000, 3, "g1");
    lfo = 8'd255;
    send_one(24'sd1000, 996, "g255");

    en = 1'b0; depth = 8'd255; lfo = 8'd0; rate = 16'd4;
    base = pulses;
    send_one(24'sd8388607, 8388607, "byp_max");
    send_one(-24'sd8388608, -8388608, "byp_min");
    chk("byp_no_pulse", pulses - base, 0);

    en = 1'b1; rate = 16'd4; base = pulses; in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_data = 24'($urandom);
      depth = 8'($urandom);
      lfo = 8'($urandom);
      tick();
    end
    chk("rate4_pulses", pulses - base, 3);
    rate = 16'd0; base = pulses;
    for (int i = 0; i < 12; i++) begin
      in_data = 24'($urandom);
      tick();
    end
    chk("rate0_pulses", pulses - base, 0);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    for (int i = 0; i < 8; i++) stim[i] = 24'($urandom);
    sent = 0; n_out = 0;
    for (int c = 0; c < 40 && n_out < 8; c++) begin
      in_valid  = (sent < 8);
      in_data   = stim[sent % 8];
      out_ready = !(c >= 3 && c < 8);
      tick();
      if (last_acc) sent++;
      if (c == 7) chk("stall_buffered", q.size(), 2);
      if (c >= 8 && c <= 10) chk("throughput", last_acc, 1);
    end
    chk("stream_count", n_out, 8);
    out_ready = 1'b1; in_valid = 1'b0;

    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      in_data   = 24'($urandom);
      depth     = 8'($urandom);
      lfo       = 8'($urandom);
      if (($urandom % 16) == 0) en = ($urandom % 4) != 0;
      if (($urandom % 32) == 0) rate = 16'($urandom_range(0, 6));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("random_drained", q.size(), 0);

    en = 1'b0; tick();
    en = 1'b1; rate = 16'd4; out_ready = 1'b0; in_valid = 1'b1;
    in_data = 24'sd1234; tick();
    in_data = -24'sd4321; tick();
    in_valid = 1'b0;
    chk("pre_rst_full", q.size(), 2);
    chk("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_lfo_nxt", lfo_nxt, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_in_ready", in_ready, 1);
    q.delete();
    cnt_m = 0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", out_valid, 0);
    out_ready = 1'b1; in_valid = 1'b1; base = pulses;
    for (int i = 0; i < 4; i++) begin
      in_data = 24'($urandom);
      tick();
      if (i == 2) chk("post_rst_early", pulses - base, 0);
    end
    chk("post_rst_pulse", pulses - base, 1);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("final_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
